// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment codes and sizing helpers.
package seg7_pkg;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Active-high code for a dark digit
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Divider counter width; never narrower than one bit so TICK_DIV=1 still builds
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment code.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    // Straight lookup; polarity and blanking are handled by the scanner
    always_comb begin
        code = SEG_OFF;
        unique case (nibble)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            4'hF: code = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed hex display driver with frame-synchronous value capture.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           value,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned            CNT_W    = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0]       DIV_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]             LAST_DIG = 3'(NUM_DIGITS - 1);
    // XOR masks that turn active-high patterns into pin levels
    localparam logic [NUM_DIGITS-1:0]  AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]             SEG_POL  = {7{ACTIVE_LOW}};
    localparam logic                   DP_OFF   = ACTIVE_LOW;

    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [2:0]            dig_idx_q, dig_idx_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  last_dig;
    logic                  blanked;
    logic [3:0]            nibble;
    logic [6:0]            digit_code;
    logic [NUM_DIGITS-1:0] an_hot;

    // Only the shadow copy is decoded, so value never reaches the pins combinationally
    assign nibble = shadow_q[{dig_idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .code   (digit_code)
    );

    // Digit select and leading-zero detection for the slot about to be driven
    always_comb begin
        an_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_hot[i] = (dig_idx_q == 3'(i));
        end
        blanked = blank_lz && (dig_idx_q != 3'd0) &&
                  ((shadow_q >> {dig_idx_q, 2'b00}) == 32'd0);
    end

    // Divider, scan sequencing and frame capture next-state
    always_comb begin
        tick         = (div_cnt_q == DIV_MAX);
        last_dig     = (dig_idx_q == LAST_DIG);
        div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
        dig_idx_d    = dig_idx_q;
        shadow_d     = shadow_q;
        an_d         = an_q;
        seg_d        = seg_q;
        frame_done_d = 1'b0;
        if (tick) begin
            an_d      = an_hot ^ AN_POL;
            seg_d     = (blanked ? SEG_OFF : digit_code) ^ SEG_POL;
            dig_idx_d = last_dig ? 3'd0 : dig_idx_q + 3'd1;
            // The last digit decodes the old shadow on this same edge
            if (last_dig) begin
                shadow_d     = value;
                frame_done_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset to the dark state
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            dig_idx_q    <= 3'd0;
            shadow_q     <= 32'd0;
            an_q         <= AN_POL;
            seg_q        <= SEG_POL;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_idx_q    <= dig_idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= DP_OFF;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
